// File: rtl/range_stats.sv
// Streaming min/max/range/count statistics over a go/finish session.
// Optional build macro RANGE_STATS_SIGNED_EN selects two's-complement min/max compares.
module range_stats #(
  parameter int WIDTH   = 10,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               valid,
  input  logic               go,
  input  logic               finish,
  input  logic [WIDTH-1:0]   threshold,
  output logic [WIDTH-1:0]   min_out,
  output logic [WIDTH-1:0]   max_out,
  output logic [WIDTH-1:0]   range,
  output logic [COUNT_W-1:0] count,
  output logic               count_sat,
  output logic               done,
  output logic               error,
  output logic               alarm
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERROR} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   min_q, min_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               count_sat_q, count_sat_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_STATS_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    done_d  = done_q;
    error_d = error_q;

    if (go && finish) begin
      state_d = ERROR;
      error_d = 1'b1;
      done_d  = 1'b0;
    end else if (go) begin
      // A start always discards the previous session's statistics.
      state_d = ACTIVE;
      error_d = 1'b0;
      done_d  = 1'b0;
      if (valid) begin
        min_d   = data_in;
        max_d   = data_in;
        count_d = CNT_ONE;
      end else begin
        min_d   = '0;
        max_d   = '0;
        count_d = '0;
      end
    end else begin
      case (state_q)
        ACTIVE: begin
          if (valid) begin
            if (count_q == '0) begin
              min_d = data_in;
              max_d = data_in;
            end else begin
              if (less_than(data_in, min_q)) min_d = data_in;
              if (less_than(max_q, data_in)) max_d = data_in;
            end
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
          end
          if (finish) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        IDLE, ERROR: begin
          if (finish) begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    count_sat_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      min_q       <= '0;
      max_q       <= '0;
      count_q     <= '0;
      count_sat_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      count_q     <= count_d;
      count_sat_q <= count_sat_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // max >= min holds under the active compare mode, so this never wraps.
  assign range     = max_q - min_q;
  assign alarm     = ((state_q == ACTIVE) || (state_q == DONE)) && (range > threshold);
  assign min_out   = min_q;
  assign max_out   = max_q;
  assign count     = count_q;
  assign count_sat = count_sat_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
